// File: rtl/irig_b_encoder.sv
// -----------------------------------------------------------------------------
// irig_b_encoder
// IRIG-B000 (DC level-shift) time-code generator. BCD time-of-year fields are
// serialised into a 100-bit, 100*CLK_PER_BIT-cycle frame of pulse-width-coded
// bits: marker = HI_P high cycles, logic 1 = HI_ONE, logic 0 = HI_ZERO.
//
// Ports
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   enable       in   frames are transmitted back-to-back while high
//   load         in   one-cycle strobe, captures the time inputs into the shadow
//   second       in   7-bit BCD  {tens[2:0], units[3:0]}
//   minute       in   7-bit BCD  {tens[2:0], units[3:0]}
//   hour         in   6-bit BCD  {tens[1:0], units[3:0]}
//   day          in  10-bit BCD  {hundreds[1:0], tens[3:0], units[3:0]}
//   year         in   8-bit BCD  {tens[3:0], units[3:0]}
//   IRIG_B       out  registered time-code line
//   frame_start  out  one-cycle pulse on the rising edge of bit 0 (Pr)
//   busy         out  high while a frame is on the line
//   bit_idx      out  index (0..99) of the current bit cell
// -----------------------------------------------------------------------------
module irig_b_encoder #(
  parameter int CLK_PER_BIT = 1250000,
  parameter int HI_P        = 1000000,
  parameter int HI_ONE      = 625000,
  parameter int HI_ZERO     = 250000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic       load,
  input  logic [6:0] second,
  input  logic [6:0] minute,
  input  logic [5:0] hour,
  input  logic [9:0] day,
  input  logic [7:0] year,
  output logic       IRIG_B,
  output logic       frame_start,
  output logic       busy,
  output logic [6:0] bit_idx
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [20:0] C_LAST    = 21'(CLK_PER_BIT - 1);
  localparam logic [20:0] C_HI_P    = 21'(HI_P);
  localparam logic [20:0] C_HI_ONE  = 21'(HI_ONE);
  localparam logic [20:0] C_HI_ZERO = 21'(HI_ZERO);

  // Time fields packed as {year, day, hour, minute, second}
  localparam int FW = 38;

  logic [0:0]    r_state;
  logic [20:0]   r_cyc_cnt;
  logic [6:0]    r_bit_idx;
  logic [FW-1:0] r_shadow;
  logic [FW-1:0] r_frame;

  logic [FW-1:0] w_in;
  logic          w_cell_end;
  logic          w_frame_end;
  logic          w_snap;
  logic [FW-1:0] w_snap_val;
  logic [99:0]   w_marker;
  logic [99:0]   w_data;
  logic [20:0]   w_hi;

  assign w_in        = {year, day, hour, minute, second};
  assign w_cell_end  = (r_cyc_cnt == C_LAST);
  assign w_frame_end = w_cell_end && (r_bit_idx == 7'd99);

  // A snapshot happens when a frame is about to begin: leaving IDLE, or at the
  // end of bit 99 with enable still high. A coincident load goes straight in.
  assign w_snap     = enable && ((r_state == S_IDLE) || w_frame_end);
  assign w_snap_val = load ? w_in : r_shadow;

  // Position markers: Pr at bit 0, P1..P0 at every bit ending in 9.
  for (genvar gi = 0; gi < 100; gi++) begin : g_marker
    assign w_marker[gi] = (gi == 0) || ((gi % 10) == 9);
  end

  // Place the BCD digits of the frame register at their bit positions.
  always_comb begin
    w_data        = '0;
    w_data[4:1]   = r_frame[3:0];    // seconds units
    w_data[8:6]   = r_frame[6:4];    // seconds tens
    w_data[13:10] = r_frame[10:7];   // minutes units
    w_data[17:15] = r_frame[13:11];  // minutes tens
    w_data[23:20] = r_frame[17:14];  // hours units
    w_data[26:25] = r_frame[19:18];  // hours tens
    w_data[33:30] = r_frame[23:20];  // day units
    w_data[38:35] = r_frame[27:24];  // day tens
    w_data[41:40] = r_frame[29:28];  // day hundreds
    w_data[53:50] = r_frame[33:30];  // year units
    w_data[58:55] = r_frame[37:34];  // year tens
  end

  assign w_hi = w_marker[r_bit_idx] ? C_HI_P :
                w_data[r_bit_idx]   ? C_HI_ONE : C_HI_ZERO;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_cyc_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shadow    <= '0;
      r_frame     <= '0;
      IRIG_B      <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (load) begin
        r_shadow <= w_in;
      end
      if (w_snap) begin
        r_frame <= w_snap_val;
      end

      // Outputs are decoded from the counters, so the line trails them by one cycle.
      IRIG_B      <= (r_state == S_SEND) && (r_cyc_cnt < w_hi);
      frame_start <= (r_state == S_SEND) && (r_cyc_cnt == '0) && (r_bit_idx == '0);
      busy        <= (r_state == S_SEND);

      case (r_state)
        S_IDLE: begin
          r_cyc_cnt <= '0;
          r_bit_idx <= '0;
          if (enable) begin
            r_state <= S_SEND;
          end
        end
        default: begin
          if (w_cell_end) begin
            r_cyc_cnt <= '0;
            if (r_bit_idx == 7'd99) begin
              r_bit_idx <= '0;
              // enable is only looked at on frame boundaries
              if (!enable) begin
                r_state <= S_IDLE;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 7'd1;
            end
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 21'd1;
          end
        end
      endcase
    end
  end

  assign bit_idx = r_bit_idx;

endmodule

// File: tb/tb_irig_b_encoder.sv
module tb_irig_b_encoder;

  localparam int CPB = 100;
  localparam int HP  = 80;
  localparam int H1  = 50;
  localparam int H0  = 20;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [6:0] second = '0;
  logic [6:0] minute = '0;
  logic [5:0] hour = '0;
  logic [9:0] day = '0;
  logic [7:0] year = '0;
  logic       IRIG_B;
  logic       frame_start;
  logic       busy;
  logic [6:0] bit_idx;

  int checks = 0;
  int errors = 0;

  irig_b_encoder #(
    .CLK_PER_BIT(CPB), .HI_P(HP), .HI_ONE(H1), .HI_ZERO(H0)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .load(load),
    .second(second), .minute(minute), .hour(hour), .day(day), .year(year),
    .IRIG_B(IRIG_B), .frame_start(frame_start), .busy(busy), .bit_idx(bit_idx)
  );

  always #5 sys_clk = ~sys_clk;

  // Time record: {year, day, hour, minute, second}
  function automatic logic [37:0] pack(logic [6:0] s, logic [6:0] m, logic [5:0] h,
                                       logic [9:0] d, logic [7:0] y);
    return {y, d, h, m, s};
  endfunction

  // Reference model: expected high time of bit b for time record f,
  // from the IRIG-B bit map (digit -> first bit position, LSB first).
  function automatic int hi_of(logic [37:0] f, int b);
    logic [6:0] s;
    logic [6:0] m;
    logic [5:0] h;
    logic [9:0] d;
    logic [7:0] y;
    int digit [11];
    int pos [11];
    int wid [11];
    if (b == 0 || b % 10 == 9) return HP;
    {y, d, h, m, s} = f;
    digit = '{int'(s[3:0]), int'(s[6:4]), int'(m[3:0]), int'(m[6:4]), int'(h[3:0]),
              int'(h[5:4]), int'(d[3:0]), int'(d[7:4]), int'(d[9:8]), int'(y[3:0]),
              int'(y[7:4])};
    pos = '{1, 6, 10, 15, 20, 25, 30, 35, 40, 50, 55};
    wid = '{4, 3, 4, 3, 4, 2, 4, 4, 2, 4, 4};
    for (int k = 0; k < 11; k++) begin
      if (b >= pos[k] && b < pos[k] + wid[k]) begin
        return (((digit[k] >> (b - pos[k])) & 1) == 1) ? H1 : H0;
      end
    end
    return H0;
  endfunction

  function automatic logic [37:0] rand_fields();
    logic [6:0] s;
    logic [6:0] m;
    logic [5:0] h;
    logic [9:0] d;
    logic [7:0] y;
    s = {3'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    m = {3'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};  // may be out of range
    h = {2'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
    d = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    y = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 9))};   // never 99
    return pack(s, m, h, d, y);
  endfunction

  task automatic drive_fields(input logic [37:0] f);
    {year, day, hour, minute, second} = f;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for frame_start, then checks the full frame against the model.
  // Optional mid-frame load (load_at >= 0) and enable drop (drop_at >= 0).
  task automatic capture(input string tag, input logic [37:0] exp_f, input int load_at,
                         input logic [37:0] load_f, input int drop_at, input bit contig);
    int  waited;
    int  hi [100];
    bit  bad [100];
    int  busy_bad;
    int  fs_bad;
    int  idx_bad;
    int  b;
    int  ph;
    waited = 0;
    busy_bad = 0;
    fs_bad = 0;
    idx_bad = 0;
    for (int i = 0; i < 100; i++) begin
      hi[i] = hi_of(exp_f, i);
      bad[i] = 1'b0;
    end
    @(negedge sys_clk);
    while (frame_start !== 1'b1 && waited < 20000) begin
      @(negedge sys_clk);
      waited++;
    end
    chk({tag, "_start_timeout"}, 32'(waited < 20000), 32'd1);
    if (contig) chk({tag, "_contiguous"}, 32'(waited), 32'd0);
    for (int c = 0; c < 100 * CPB; c++) begin
      if (c > 0) @(negedge sys_clk);
      b  = c / CPB;
      ph = c % CPB;
      if (IRIG_B !== ((ph < hi[b]) ? 1'b1 : 1'b0)) bad[b] = 1'b1;
      if (busy !== 1'b1) busy_bad++;
      if (frame_start !== ((c == 0) ? 1'b1 : 1'b0)) fs_bad++;
      if (bit_idx !== 7'(((c + 1) / CPB) % 100)) idx_bad++;
      if (c == load_at) begin
        load = 1'b1;
        drive_fields(load_f);
      end else begin
        load = 1'b0;
      end
      if (c == drop_at) enable = 1'b0;
    end
    load = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("%s_bit%0d_shape", tag, i), 32'(bad[i]), 32'd0);
    end
    chk({tag, "_busy_low_cycles"}, 32'(busy_bad), 32'd0);
    chk({tag, "_frame_start_errs"}, 32'(fs_bad), 32'd0);
    chk({tag, "_bit_idx_errs"}, 32'(idx_bad), 32'd0);
    $display("frame %s fields=%h waited=%0d bad_busy=%0d bad_fs=%0d bad_idx=%0d",
             tag, exp_f, waited, busy_bad, fs_bad, idx_bad);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    int hi_cnt;
    int fs_cnt;
    hi_cnt = 0;
    fs_cnt = 0;
    @(negedge sys_clk);
    chk({tag, "_busy_fell"}, 32'(busy), 32'd0);
    chk({tag, "_line_low"}, 32'(IRIG_B), 32'd0);
    for (int c = 0; c < cycles; c++) begin
      @(negedge sys_clk);
      if (IRIG_B !== 1'b0) hi_cnt++;
      if (frame_start !== 1'b0) fs_cnt++;
    end
    chk({tag, "_idle_high_cycles"}, 32'(hi_cnt), 32'd0);
    chk({tag, "_idle_fs_pulses"}, 32'(fs_cnt), 32'd0);
    $display("idle %s high=%0d fs=%0d", tag, hi_cnt, fs_cnt);
  endtask

  initial begin
    logic [37:0] f1;
    logic [37:0] f2;
    logic [37:0] r1;
    logic [37:0] r2;
    logic [37:0] r3;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_irig", 32'(IRIG_B), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bit_idx", 32'(bit_idx), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("idle_irig", 32'(IRIG_B), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Scenario 1 + 3: known fields, minute 30 -> 31 loaded mid-frame
    f1 = pack(7'h25, 7'h30, 6'h12, 10'h123, 8'h24);
    f2 = pack(7'h25, 7'h31, 6'h12, 10'h123, 8'h24);
    load = 1'b1;
    drive_fields(f1);
    @(negedge sys_clk);
    load = 1'b0;
    enable = 1'b1;
    capture("s1_first", f1, 3000, f2, -1, 1'b0);
    r1 = rand_fields();
    capture("s3_minute31", f2, 5000, r1, -1, 1'b1);

    // Scenario 4: random fields, enable dropped at bit 40
    capture("s4_drop", r1, -1, r1, 4000, 1'b1);
    check_idle("s4", 300);

    // Scenario 5: load on the snapshot cycle goes into that frame
    r2 = rand_fields();
    r2[37:30] = 8'h99;
    load = 1'b1;
    enable = 1'b1;
    drive_fields(r2);
    capture("s5_bypass", r2, -1, r2, 100, 1'b0);
    check_idle("s5", 50);

    // Scenario 6: reset during bit 57, then a fresh all-zero frame
    r3 = rand_fields();
    load = 1'b1;
    drive_fields(r3);
    @(negedge sys_clk);
    load = 1'b0;
    enable = 1'b1;
    begin
      int waited;
      waited = 0;
      while (frame_start !== 1'b1 && waited < 20000) begin
        @(negedge sys_clk);
        waited++;
      end
      chk("s6_start_timeout", 32'(waited < 20000), 32'd1);
    end
    repeat (5750) @(negedge sys_clk);
    chk("s6_pre_bit_idx", 32'(bit_idx), 32'd57);
    sys_rst_n = 1'b0;
    #1;
    chk("s6_rst_irig", 32'(IRIG_B), 32'd0);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    chk("s6_rst_bit_idx", 32'(bit_idx), 32'd0);
    chk("s6_rst_fs", 32'(frame_start), 32'd0);
    $display("reset s6 mid-frame irig=%0b busy=%0b bit_idx=%0d", IRIG_B, busy, bit_idx);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    capture("s6_cleared", '0, -1, '0, 100, 1'b0);
    check_idle("s6", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irig_b_encoder.md
# irig_b_encoder

IRIG-B000 (DC level-shift, unmodulated) time-code generator. Serialises BCD time-of-year fields into the standard 100-bit, 1 s frame of pulse-width-coded bits on `IRIG_B`. Sits directly upstream of the IRIG-B decoder and drives its `IRIG_B` input. It is the synthesizable source used for loopback and self-test of the decoder; its field widths match the decoder outputs one-to-one.

## Interface
Parameters:
- `CLK_PER_BIT`, default 1250000: clocks per 10 ms bit cell at 125 MHz.
- `HI_P`, default 1000000: high time of a position marker (8 ms).
- `HI_ONE`, default 625000: high time of a logic 1 (5 ms).
- `HI_ZERO`, default 250000: high time of a logic 0 (2 ms).

Ports:
- `sys_clk`  in  1: system clock, 125 MHz.
- `sys_rst_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: level; frames transmit while high.
- `load`  in  1: one-cycle strobe; captures the five time inputs into the shadow register.
- `second`  in  7: BCD, [3:0] units, [6:4] tens.
- `minute`  in  7: BCD, [3:0] units, [6:4] tens.
- `hour`  in  6: BCD, [3:0] units, [5:4] tens.
- `day`  in  10: BCD, [3:0] units, [7:4] tens, [9:8] hundreds.
- `year`  in  8: BCD, [3:0] units, [7:4] tens.
- `IRIG_B`  out  1: registered time-code output.
- `frame_start`  out  1: one-cycle pulse on the rising edge of bit 0 (Pr).
- `busy`  out  1: high while a frame is in progress.
- `bit_idx`  out  7: index (0–99) of the bit currently on the line.

## Operation
- State machine `IDLE` → `SEND` → (`SEND` | `IDLE`).
  - `IDLE`: `IRIG_B`=0, counters at 0. If `enable`=1, snapshot the shadow register into the frame register and go to `SEND`.
  - `SEND`: `cyc_cnt` counts 0..`CLK_PER_BIT`-1. At wrap, `bit_idx` increments.
  - At the end of bit 99: if `enable`=1, re-snapshot and restart at bit 0 with no gap. Otherwise go to `IDLE`.
- `enable` deasserted mid-frame: the current frame completes in full; deassertion takes effect only at a frame boundary.
- `load` in any state updates the shadow register. If `load` coincides with a snapshot cycle, the new values bypass the shadow register and go into that frame.
- Bit map (LSB first within each digit; every unlisted non-marker bit is 0):
  - Markers: Pr=0; P1..P9 and P0 = 9, 19, 29, 39, 49, 59, 69, 79, 89, 99.
  - Seconds: units 1–4, tens 6–8.
  - Minutes: units 10–13, tens 15–17.
  - Hours: units 20–23, tens 25–26.
  - Day: units 30–33, tens 35–38, hundreds 40–41.
  - Year: units 50–53, tens 55–58.
  - Control / straight-binary-seconds bits 60–98: 0.
- Per-bit high time: `HI_P` if marker; else `HI_ONE` if data bit is 1; else `HI_ZERO`.
- Out-of-range BCD digits (>9) are transmitted unmodified; no checking.

## Timing
- Reset values: `IRIG_B`=0, `frame_start`=0, `busy`=0, `bit_idx`=0, state `IDLE`, shadow and frame registers all 0.
- Reset mid-frame: all of the above apply asynchronously, immediately.
- Frame start:
  - Edge N samples `enable`=1 in `IDLE`, so state=`SEND` and `cyc_cnt`=0 after edge N.
  - Edge N+1: `IRIG_B`=1, `frame_start`=1 (for this one cycle), `busy`=1.
- Output rule: `IRIG_B` <= (`cyc_cnt` < high time of `bit_idx`). The output lags the counter by one cycle.
  - A marker is high for exactly `HI_P` cycles, then low for `CLK_PER_BIT`-`HI_P` cycles.
- Frame length: exactly 100×`CLK_PER_BIT` cycles. Consecutive frames are contiguous: Pr follows P0 with no idle cycle.
- `bit_idx` changes on the same edge that `cyc_cnt` wraps to 0.
- Frame end:
  - `busy` falls on the edge that returns to `IDLE`.
  - `IRIG_B` falls no later than `HI_*` cycles into bit 99 and stays 0 in `IDLE`.
- Constraints: `HI_ZERO` < `HI_ONE` < `HI_P` < `CLK_PER_BIT`. `cyc_cnt` is 21 bits.

## Test plan
All scenarios use `CLK_PER_BIT`=100, `HI_P`=80, `HI_ONE`=50, `HI_ZERO`=20.
1. Reset, `load` {second=7'h25, minute=7'h30, hour=6'h12, day=10'h123, year=8'h24}, `enable`=1.
   - Bits 0 and 1 measure 80 then 50 high cycles.
   - Bits 1–4 = 1,0,1,0; bits 6–8 = 0,1,0.
   - All ten markers = 80 cycles high.
2. Scenario 1 waveform fed to the decoder → decoder outputs second=7'h25, minute=7'h30, hour=6'h12, day=10'h123, year=8'h24 after one frame.
3. Continuous `enable`, `load` minute=7'h31 mid-frame → current frame still carries 30; next frame carries 31; `frame_start` pulses exactly 10000 cycles apart.
4. `enable` dropped at bit 40 → frame runs through bit 99; `busy` falls 10000 cycles after `frame_start`; `IRIG_B` stays 0 afterwards.
5. `load` asserted on the snapshot cycle with year=8'h99 → that same frame transmits year 99.
6. `sys_rst_n` pulsed low during bit 57 → `IRIG_B`=0, `busy`=0, `bit_idx`=0 immediately. After release with `enable`=1, a fresh frame starts from Pr with the shadow register cleared (all data bits 0).
